qtable_responder: RTL

- Memory-side responder for the Q-learning pipeline's Q-table read/write port.
- Stores Q(s,a) and maintains a per-state max table (value and argmax action) that the pipeline reads as Qmax.
- Replaces separate qtable/qmaxtable instances. Qmax is derived from Q writes, so the pipeline no longer writes it.
- Handles read/write collisions, power-up clearing, and argmax recomputation when a write lowers the current max holder.

---
 rtl/qtable_responder_if.sv | 39 +++
 rtl/qtable_responder.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/qtable_responder_if.sv
// Q-table request/response bus between the learning pipeline and the
// responder. Master = pipeline, slave = qtable_responder.
interface qtable_responder_if #(
  parameter int STATE_W = 6,
  parameter int ACT_W   = 2,
  parameter int DATA_W  = 8
);
  localparam int AW = STATE_W + ACT_W;

  logic              o_ready;
  logic              i_read_en;
  logic [AW-1:0]     i_addr_r;
  logic [DATA_W-1:0] o_data;
  logic              o_rvalid;
  logic              i_write_en;
  logic [AW-1:0]     i_addr_w;
  logic [DATA_W-1:0] i_data;
  logic              i_max_rd_en;
  logic [STATE_W-1:0] i_max_addr;
  logic [DATA_W-1:0] o_max_data;
  logic [ACT_W-1:0]  o_max_act;
  logic              o_max_valid;

  modport master (
    input  o_ready, o_data, o_rvalid,
    input  o_max_data, o_max_act, o_max_valid,
    output i_read_en, i_addr_r,
    output i_write_en, i_addr_w, i_data,
    output i_max_rd_en, i_max_addr
  );

  modport slave (
    output o_ready, o_data, o_rvalid,
    output o_max_data, o_max_act, o_max_valid,
    input  i_read_en, i_addr_r,
    input  i_write_en, i_addr_w, i_data,
    input  i_max_rd_en, i_max_addr
  );
endinterface

// File: rtl/qtable_responder.sv
// Q-table responder: Q(s,a) store plus per-state max/argmax table.
// Ports: i_clk, i_rst_n (sync, active low), bus (slave modport).
// QTABLE_STATS_EN adds o_write_cnt / o_rescan_cnt (16-bit, saturating).
module qtable_responder #(
  parameter int STATE_W = 6,
  parameter int ACT_W   = 2,
  parameter int DATA_W  = 8
) (
  input  logic i_clk,
  input  logic i_rst_n,
  qtable_responder_if.slave bus
`ifdef QTABLE_STATS_EN
  ,
  output logic [15:0] o_write_cnt,
  output logic [15:0] o_rescan_cnt
`endif
);
  localparam int AW = STATE_W + ACT_W;
  localparam int NQ = 1 << AW;
  localparam int NS = 1 << STATE_W;
  localparam int NA = 1 << ACT_W;

  typedef enum logic [1:0] {
    CLEAR,
    IDLE,
    RESCAN
  } state_t;

  state_t state, state_d;

  logic [AW-1:0] cnt, cnt_d;
  logic [STATE_W-1:0] rs_state, rs_state_d;
  logic [DATA_W-1:0] rs_q;
  logic [DATA_W-1:0] best_val, best_val_d;
  logic [ACT_W-1:0] best_act, best_act_d;

  logic [DATA_W-1:0] q_mem   [NQ];
  logic [DATA_W-1:0] max_val [NS];
  logic [ACT_W-1:0]  max_act [NS];

  logic              q_we;
  logic [AW-1:0]     q_wa;
  logic [DATA_W-1:0] q_wd;
  logic              m_we;
  logic [STATE_W-1:0] m_wa;
  logic [DATA_W-1:0] m_wd;
  logic [ACT_W-1:0]  m_wact;
  logic              rescan_start;

  logic ready;
  logic rd_acc, wr_acc, mx_acc;
  logic [STATE_W-1:0] w_state;
  logic [ACT_W-1:0]   w_act;
  logic [DATA_W-1:0]  cur_max;
  logic [ACT_W-1:0]   cur_act;
  logic raise, lower;

  logic [ACT_W:0] rs_step;
  logic take;

  assign ready       = (state == IDLE);
  assign bus.o_ready = ready;

  assign rd_acc = bus.i_read_en   & ready;
  assign wr_acc = bus.i_write_en  & ready;
  assign mx_acc = bus.i_max_rd_en & ready;

  assign w_state = bus.i_addr_w[AW-1:ACT_W];
  assign w_act   = bus.i_addr_w[ACT_W-1:0];
  assign cur_max = max_val[w_state];
  assign cur_act = max_act[w_state];

  assign raise = wr_acc && (bus.i_data > cur_max);
  assign lower = wr_acc && (w_act == cur_act)
               && (bus.i_data < cur_max);

  // rs_q holds Q[s, rs_step-1]; strict '>' keeps the lowest action on ties
  assign rs_step = cnt[ACT_W:0];
  assign take    = (rs_step == (ACT_W+1)'(1)) || (rs_q > best_val);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state    <= CLEAR;
      cnt      <= '0;
      rs_state <= '0;
      rs_q     <= '0;
      best_val <= '0;
      best_act <= '0;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      rs_state <= rs_state_d;
      rs_q     <= q_mem[{rs_state, cnt[ACT_W-1:0]}];
      best_val <= best_val_d;
      best_act <= best_act_d;
    end
  end

  always_comb begin
    state_d      = state;
    cnt_d        = cnt;
    rs_state_d   = rs_state;
    best_val_d   = best_val;
    best_act_d   = best_act;
    q_we         = 1'b0;
    q_wa         = '0;
    q_wd         = '0;
    m_we         = 1'b0;
    m_wa         = '0;
    m_wd         = '0;
    m_wact       = '0;
    rescan_start = 1'b0;

    unique case (state)
      CLEAR: begin
        q_we  = 1'b1;
        q_wa  = cnt;
        m_we  = (cnt[ACT_W-1:0] == '0);
        m_wa  = cnt[AW-1:ACT_W];
        cnt_d = cnt + AW'(1);
        if (cnt == {AW{1'b1}})
          state_d = IDLE;
      end
      IDLE: begin
        if (wr_acc) begin
          q_we = 1'b1;
          q_wa = bus.i_addr_w;
          q_wd = bus.i_data;
        end
        if (raise) begin
          m_we   = 1'b1;
          m_wa   = w_state;
          m_wd   = bus.i_data;
          m_wact = w_act;
        end else if (lower) begin
          state_d      = RESCAN;
          rs_state_d   = w_state;
          cnt_d        = '0;
          rescan_start = 1'b1;
        end
      end
      RESCAN: begin
        cnt_d = cnt + AW'(1);
        if (rs_step != '0 && take) begin
          best_val_d = rs_q;
          best_act_d = ACT_W'(rs_step - (ACT_W+1)'(1));
        end
        if (rs_step == (ACT_W+1)'(NA)) begin
          m_we    = 1'b1;
          m_wa    = rs_state;
          m_wd    = best_val_d;
          m_wact  = best_act_d;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = CLEAR;
    endcase

    // reset aborts any in-flight table update
    if (!i_rst_n) begin
      q_we = 1'b0;
      m_we = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (q_we)
      q_mem[q_wa] <= q_wd;
    if (m_we) begin
      max_val[m_wa] <= m_wd;
      max_act[m_wa] <= m_wact;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      bus.o_data      <= '0;
      bus.o_rvalid    <= 1'b0;
      bus.o_max_data  <= '0;
      bus.o_max_act   <= '0;
      bus.o_max_valid <= 1'b0;
    end else begin
      bus.o_rvalid    <= rd_acc;
      bus.o_max_valid <= mx_acc;
      if (rd_acc) begin
        if (wr_acc && bus.i_addr_w == bus.i_addr_r)
          bus.o_data <= bus.i_data;
        else
          bus.o_data <= q_mem[bus.i_addr_r];
      end
      // max table array is read before this edge's update lands
      if (mx_acc) begin
        bus.o_max_data <= max_val[bus.i_max_addr];
        bus.o_max_act  <= max_act[bus.i_max_addr];
      end
    end
  end

`ifdef QTABLE_STATS_EN
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_write_cnt  <= '0;
      o_rescan_cnt <= '0;
    end else begin
      if (wr_acc && o_write_cnt != 16'hFFFF)
        o_write_cnt <= o_write_cnt + 16'd1;
      if (rescan_start && o_rescan_cnt != 16'hFFFF)
        o_rescan_cnt <= o_rescan_cnt + 16'd1;
    end
  end
`endif
endmodule
